// File: rtl/l1a_trigger_emulator_pkg.sv
// Shared types for the L1A trigger emulator: trigger modes, burst FSM states
// and the LFSR tap table.
// Imported by the LFSR sub-module and the emulator top.
package l1a_emu_pkg;

  typedef enum logic [1:0] {
    MODE_RANDOM   = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_SINGLE   = 2'd2,
    MODE_BURST    = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } burst_state_e;

  // 1-based tap positions of a maximal-length Fibonacci LFSR
  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
  } taps_t;

  function automatic taps_t lfsr_taps(input int width);
    taps_t t;
    case (width)
      23:      t = '{hi: 8'd23, lo: 8'd18};
      31:      t = '{hi: 8'd31, lo: 8'd28};
      default: t = '{hi: 8'd15, lo: 8'd14};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/l1a_trigger_emulator_if.sv
// Control/status bundle of the L1A trigger emulator.
// master: trigger configuration and software strobes in, L1A outputs and counters back.
// slave: the emulator side.
interface l1a_trigger_emulator_if #(
  parameter int RATE_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
);
  logic                   dis;
  logic [1:0]             mode;
  logic [RATE_WIDTH-1:0]  threshold;
  logic [11:0]            period;
  logic [7:0]             min_gap;
  logic                   sw_trig;
  logic [3:0]             burst_len;
  logic                   L1A_early;
  logic                   L1A;
  logic                   busy;
  logic [COUNT_WIDTH-1:0] l1a_count;
  logic [COUNT_WIDTH-1:0] suppressed_count;

  modport master (
    output dis, mode, threshold, period, min_gap, sw_trig, burst_len,
    input  L1A_early, L1A, busy, l1a_count, suppressed_count
  );

  modport slave (
    input  dis, mode, threshold, period, min_gap, sw_trig, burst_len,
    output L1A_early, L1A, busy, l1a_count, suppressed_count
  );
endinterface

// File: rtl/l1a_trigger_emulator_lfsr.sv
// Free-running Fibonacci LFSR with zero lockout, advancing every clock.
// Ports: clk, reset (sync, active-low), state (current LFSR value).
// A zero SEED is replaced by 1 so the register can never start locked up.
module l1a_lfsr
  import l1a_emu_pkg::*;
#(
  parameter int               WIDTH = 15,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] state
);
  localparam taps_t            TAPS   = lfsr_taps(WIDTH);
  localparam int               TAP_HI = int'(TAPS.hi) - 1;
  localparam int               TAP_LO = int'(TAPS.lo) - 1;
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] INIT   = (SEED == '0) ? ONE : SEED;

  logic [WIDTH-1:0] nxt;

  assign nxt = {state[WIDTH-2:0], state[TAP_HI] ^ state[TAP_LO]};

  always_ff @(posedge clk) begin
    if (!reset)
      state <= INIT;
    else if (nxt == '0)
      state <= ONE;
    else
      state <= nxt;
  end
endmodule

// File: rtl/l1a_trigger_emulator.sv
// Multi-mode L1A trigger source: random, periodic, single-shot and burst candidates,
// filtered by a minimum-gap rule, emitted as L1A_early and LOOKAHEAD cycles later as L1A.
// Ports: clk, reset (sync, active-low), bus (slave modport: config in, L1A/busy/counters out).
module l1a_trigger_emulator
  import l1a_emu_pkg::*;
#(
  parameter int                    LFSR_WIDTH  = 15,
  parameter logic [LFSR_WIDTH-1:0] SEED        = '1,
  parameter int                    RATE_WIDTH  = 8,
  parameter int                    LOOKAHEAD   = 4,
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  l1a_trigger_emulator_if.slave  bus
);
  logic [LFSR_WIDTH-1:0]  lfsr;
  logic                   lfsr_unused;
  logic [1:0]             mode_q;
  logic                   mode_chg;
  mode_e                  cur_mode;
  logic [11:0]            per_cnt;
  logic [7:0]             gap_cnt;
  logic [7:0]             spacing;
  logic [7:0]             burst_gap;
  logic [3:0]             remaining;
  burst_state_e           bstate;
  logic                   busy_q;
  logic                   early_q;
  logic [LOOKAHEAD-1:0]   dly;
  logic [COUNT_WIDTH-1:0] l1a_cnt;
  logic [COUNT_WIDTH-1:0] sup_cnt;
  logic                   per_hit, burst_start, burst_fire;
  logic                   cand, accept, veto;

  l1a_lfsr #(.WIDTH(LFSR_WIDTH), .SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr)
  );

  // Only the low RATE_WIDTH bits take part in the rate comparison.
  assign lfsr_unused = ^lfsr[LFSR_WIDTH-1:RATE_WIDTH];

  assign cur_mode = mode_e'(bus.mode);
  // mode_q follows mode even during reset, so leaving reset is never a mode change.
  assign mode_chg = (bus.mode != mode_q);

  always_comb begin
    per_hit     = (bus.period != 12'd0) && (per_cnt == bus.period - 12'd1);
    burst_start = (bstate == IDLE) && bus.sw_trig && (bus.burst_len != 4'd0);
    burst_fire  = (bstate == ACTIVE) && (spacing == 8'd0);
    cand        = 1'b0;
    case (cur_mode)
      MODE_RANDOM:   cand = (lfsr[RATE_WIDTH-1:0] < bus.threshold);
      MODE_PERIODIC: cand = per_hit && !mode_chg;
      MODE_SINGLE:   cand = bus.sw_trig;
      default:       cand = (burst_start || burst_fire) && !mode_chg;
    endcase
    accept = cand && !bus.dis && (gap_cnt == 8'd0);
    veto   = cand && !bus.dis && (gap_cnt != 8'd0);
  end

  always_ff @(posedge clk) begin
    mode_q <= bus.mode;
    if (!reset) begin
      per_cnt   <= '0;
      gap_cnt   <= '0;
      spacing   <= '0;
      burst_gap <= '0;
      remaining <= '0;
      bstate    <= IDLE;
      busy_q    <= 1'b0;
      early_q   <= 1'b0;
      dly       <= '0;
      l1a_cnt   <= '0;
      sup_cnt   <= '0;
    end else begin
      // Period counter: free-runs 0..period-1 in periodic mode, wraps early if
      // period shrinks below the current count.
      if (mode_chg || cur_mode != MODE_PERIODIC || bus.period == 12'd0 ||
          per_cnt >= bus.period - 12'd1)
        per_cnt <= '0;
      else
        per_cnt <= per_cnt + 12'd1;

      // Burst FSM keeps stepping under dis; its candidates are simply not accepted.
      if (mode_chg || cur_mode != MODE_BURST) begin
        bstate <= IDLE;
      end else begin
        case (bstate)
          IDLE: begin
            if (burst_start) begin
              remaining <= bus.burst_len - 4'd1;
              spacing   <= bus.min_gap;
              burst_gap <= bus.min_gap;
              if (bus.burst_len != 4'd1)
                bstate <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (spacing != 8'd0) begin
              spacing <= spacing - 8'd1;
            end else begin
              spacing <= burst_gap;
              if (remaining <= 4'd1)
                bstate <= IDLE;
              else
                remaining <= remaining - 4'd1;
            end
          end
          default: bstate <= IDLE;
        endcase
      end

      // busy is aligned with L1A_early: high from the first to the last burst pulse.
      busy_q <= (cur_mode == MODE_BURST) && !mode_chg &&
                (burst_start || bstate == ACTIVE);

      if (accept)
        gap_cnt <= bus.min_gap;
      else if (gap_cnt != 8'd0)
        gap_cnt <= gap_cnt - 8'd1;

      early_q <= accept;
      dly[0]  <= early_q;
      for (int i = 1; i < LOOKAHEAD; i++)
        dly[i] <= dly[i-1];

      if (dly[LOOKAHEAD-1] && l1a_cnt != '1)
        l1a_cnt <= l1a_cnt + COUNT_WIDTH'(1);
      if (veto && sup_cnt != '1)
        sup_cnt <= sup_cnt + COUNT_WIDTH'(1);
    end
  end

  assign bus.L1A_early        = early_q;
  assign bus.L1A              = dly[LOOKAHEAD-1];
  assign bus.busy             = busy_q;
  assign bus.l1a_count        = l1a_cnt;
  assign bus.suppressed_count = sup_cnt;
endmodule
